// File: rtl/udma_sdio_cmd_seq.sv
// SDIO command sequencer: programs op/arg/setup/start, polls STATUS, clears flags, reads RSP0.
// Optional poll timeout enabled by defining SDIO_CMD_SEQ_TIMEOUT_EN.
module udma_sdio_cmd_seq #(
  parameter int unsigned POLL_TIMEOUT = 65535,
  parameter logic [4:0]  RSP_ADDR     = 5'h0C
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [5:0]  req_cmd_op_i,
  input  logic [2:0]  req_rsp_type_i,
  input  logic [1:0]  req_stopopt_i,
  input  logic [31:0] req_cmd_arg_i,
  input  logic [31:0] req_data_setup_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_data_o,
  output logic [15:0] rsp_status_o,
  output logic        rsp_err_o,
  output logic        rsp_timeout_o,
  output logic [4:0]  cfg_addr_o,
  output logic [31:0] cfg_data_o,
  output logic        cfg_valid_o,
  output logic        cfg_rwn_o,
  input  logic [31:0] cfg_data_i,
  input  logic        cfg_ready_i
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_OP, S_WR_ARG, S_WR_SETUP, S_WR_START,
    S_POLL, S_CLR, S_RD_RSP, S_DONE
  } state_e;

  localparam logic [4:0] ADDR_CMD_OP = 5'h08;
  localparam logic [4:0] ADDR_ARG    = 5'h09;
  localparam logic [4:0] ADDR_SETUP  = 5'h0A;
  localparam logic [4:0] ADDR_START  = 5'h0B;
  localparam logic [4:0] ADDR_STATUS = 5'h11;

  state_e      state_q, state_d;
  logic [5:0]  cmd_op_q;
  logic [2:0]  rsp_type_q;
  logic [1:0]  stopopt_q;
  logic [31:0] arg_q;
  logic [31:0] setup_q;
  logic [1:0]  flags_q;
  logic [15:0] status_q;
  logic [31:0] rsp_data_q;
  logic [15:0] rsp_status_q;
  logic        rsp_err_q;
  logic        req_fire, cfg_fire, flag_hit, to_hit, load_rsp;

  assign req_ready_o  = (state_q == S_IDLE) && !rst_i;
  assign req_fire     = req_valid_i && req_ready_o;
  assign cfg_fire     = cfg_valid_o && cfg_ready_i;
  assign flag_hit     = (state_q == S_POLL) && cfg_fire && (cfg_data_i[1:0] != 2'b00);
  assign load_rsp     = (state_d == S_DONE) && (state_q != S_DONE);
  assign rsp_valid_o  = (state_q == S_DONE);
  assign rsp_data_o   = rsp_data_q;
  assign rsp_status_o = rsp_status_q;
  assign rsp_err_o    = rsp_err_q;

`ifdef SDIO_CMD_SEQ_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(POLL_TIMEOUT);
  logic [15:0] poll_cnt_q;
  logic        rsp_timeout_q;

  assign to_hit        = (state_q == S_POLL) && cfg_fire && !flag_hit &&
                         ((poll_cnt_q + 16'd1) == TO_LIM);
  assign rsp_timeout_o = rsp_timeout_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      poll_cnt_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      if (req_fire)
        poll_cnt_q <= '0;
      else if ((state_q == S_POLL) && cfg_fire)
        poll_cnt_q <= poll_cnt_q + 16'd1;
      if (load_rsp)
        rsp_timeout_q <= to_hit;
    end
  end
`else
  logic unused_poll_timeout;
  assign unused_poll_timeout = |16'(POLL_TIMEOUT);
  assign to_hit              = 1'b0;
  assign rsp_timeout_o       = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cfg_valid_o = 1'b0;
    cfg_rwn_o   = 1'b0;
    cfg_addr_o  = '0;
    cfg_data_o  = '0;
    unique case (state_q)
      S_IDLE: if (req_fire) state_d = S_WR_OP;
      S_WR_OP: begin
        cfg_valid_o = 1'b1;
        cfg_addr_o  = ADDR_CMD_OP;
        cfg_data_o  = {14'h0, stopopt_q, 2'b00, cmd_op_q, 5'h00, rsp_type_q};
        if (cfg_fire) state_d = S_WR_ARG;
      end
      S_WR_ARG: begin
        cfg_valid_o = 1'b1;
        cfg_addr_o  = ADDR_ARG;
        cfg_data_o  = arg_q;
        if (cfg_fire) state_d = S_WR_SETUP;
      end
      S_WR_SETUP: begin
        cfg_valid_o = 1'b1;
        cfg_addr_o  = ADDR_SETUP;
        cfg_data_o  = setup_q;
        if (cfg_fire) state_d = S_WR_START;
      end
      S_WR_START: begin
        cfg_valid_o = 1'b1;
        cfg_addr_o  = ADDR_START;
        cfg_data_o  = 32'h1;
        if (cfg_fire) state_d = S_POLL;
      end
      S_POLL: begin
        cfg_valid_o = 1'b1;
        cfg_rwn_o   = 1'b1;
        cfg_addr_o  = ADDR_STATUS;
        if (flag_hit)    state_d = S_CLR;
        else if (to_hit) state_d = S_DONE;
      end
      S_CLR: begin
        // write-one-to-clear only the flags seen, so a later event is not lost
        cfg_valid_o = 1'b1;
        cfg_addr_o  = ADDR_STATUS;
        cfg_data_o  = {30'h0, flags_q};
        if (cfg_fire) state_d = flags_q[1] ? S_DONE : S_RD_RSP;
      end
      S_RD_RSP: begin
        cfg_valid_o = 1'b1;
        cfg_rwn_o   = 1'b1;
        cfg_addr_o  = RSP_ADDR;
        if (cfg_fire) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cmd_op_q     <= '0;
      rsp_type_q   <= '0;
      stopopt_q    <= '0;
      arg_q        <= '0;
      setup_q      <= '0;
      flags_q      <= '0;
      status_q     <= '0;
      rsp_data_q   <= '0;
      rsp_status_q <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (req_fire) begin
        cmd_op_q   <= req_cmd_op_i;
        rsp_type_q <= req_rsp_type_i;
        stopopt_q  <= req_stopopt_i;
        arg_q      <= req_cmd_arg_i;
        setup_q    <= req_data_setup_i;
        flags_q    <= '0;
        status_q   <= '0;
      end
      if (flag_hit) begin
        flags_q  <= cfg_data_i[1:0];
        status_q <= cfg_data_i[31:16];
      end
      // result registers change only on entry to DONE so they hold between responses
      if (load_rsp) begin
        rsp_data_q   <= (state_q == S_RD_RSP) ? cfg_data_i : '0;
        rsp_status_q <= status_q;
        rsp_err_q    <= flags_q[1] | to_hit;
      end
    end
  end

endmodule

// File: doc/udma_sdio_cmd_seq.md
UDMA_SDIO_CMD_SEQ -- requirements
Module: udma_sdio_cmd_seq

Interface
REQ-001 SHALL have parameter POLL_TIMEOUT, default 65535, the maximum number of STATUS poll reads before the sequencer aborts (16-bit).
REQ-002 SHALL have parameter RSP_ADDR, default 5'h0C, the cfg word address read for the response word (RSP0).
REQ-003 SHALL have port clk_i, input, 1, the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have requester ports: req_valid_i (in, 1), req_ready_o (out, 1), req_cmd_op_i (in, 6), req_rsp_type_i (in, 3), req_stopopt_i (in, 2), req_cmd_arg_i (in, 32), req_data_setup_i (in, 32).
REQ-006 SHALL have result ports: rsp_valid_o (out, 1), rsp_data_o (out, 32), rsp_status_o (out, 16), rsp_err_o (out, 1), rsp_timeout_o (out, 1).
REQ-007 SHALL have cfg master ports driving the SDIO register block: cfg_addr_o (out, 5), cfg_data_o (out, 32), cfg_valid_o (out, 1), cfg_rwn_o (out, 1), cfg_data_i (in, 32), cfg_ready_i (in, 1).

Function
REQ-008 SHALL accept a request only on the cycle where req_valid_i & req_ready_o, capturing all req_* fields; req_ready_o = 1 only in IDLE.
REQ-009 SHALL complete a cfg transaction on the cycle where cfg_valid_o & cfg_ready_i; cfg_addr_o/cfg_data_o/cfg_rwn_o SHALL hold stable while cfg_valid_o = 1 and not accepted.
REQ-010 SHALL implement the states IDLE -> WR_OP -> WR_ARG -> WR_SETUP -> WR_START -> POLL -> CLR -> RD_RSP -> DONE -> IDLE, each cfg state issuing exactly one transaction and advancing on its completion.
REQ-011 SHALL, in WR_OP, write addr 5'h08 with data {14'h0, stopopt, 2'b00, cmd_op, 5'h00, rsp_type}.
REQ-012 SHALL, in WR_ARG, write addr 5'h09 with cmd_arg; in WR_SETUP, write addr 5'h0A with data_setup verbatim; in WR_START, write addr 5'h0B with 32'h1.
REQ-013 SHALL, in POLL, issue reads of addr 5'h11 back to back; on a completed read with cfg_data_i[1:0] != 0, latch status = cfg_data_i[31:16], err = cfg_data_i[1], and go to CLR.
REQ-014 SHALL, in CLR, write addr 5'h11 with {30'h0, latched bit1, latched bit0}, clearing exactly the flags observed.
REQ-015 SHALL, in RD_RSP, read RSP_ADDR and latch cfg_data_i; when err = 1, RD_RSP is skipped and rsp_data_o = 0.
REQ-016 SHALL, in DONE, pulse rsp_valid_o for exactly one cycle with the latched data, status, err and timeout; these outputs SHALL hold their values until the next DONE.
REQ-017 SHALL treat eot and err both set in the same poll read as an error (rsp_err_o = 1) and clear both in CLR.
REQ-018 SHALL ignore req_valid_i while not in IDLE; a request held across DONE is accepted on the first IDLE cycle.
REQ-019 SHALL produce at minimum 8 cycles from acceptance to rsp_valid_o with cfg_ready_i tied high and eot seen on the first poll.

Reset
REQ-020 SHALL, while rst_i = 1, enter IDLE and drive req_ready_o = 0, cfg_valid_o = 0, cfg_rwn_o = 0, cfg_addr_o = 0, cfg_data_o = 0, rsp_valid_o = 0, rsp_data_o = 0, rsp_status_o = 0, rsp_err_o = 0, rsp_timeout_o = 0, and poll counter = 0.
REQ-021 SHALL, on reset asserted mid-sequence, abandon the sequence without a rsp_valid_o pulse and deassert cfg_valid_o on the next edge; req_ready_o = 1 on the first cycle after rst_i drops.

Configuration
REQ-022 SHALL support macro SDIO_CMD_SEQ_TIMEOUT_EN; when defined, a 16-bit counter SHALL count completed POLL reads and, when it reaches POLL_TIMEOUT without a flag, go to DONE with rsp_timeout_o = 1, rsp_err_o = 1, and rsp_data_o = 0, skipping CLR and RD_RSP.
REQ-023 SHALL, when SDIO_CMD_SEQ_TIMEOUT_EN is undefined, poll indefinitely; rsp_timeout_o is tied 0 and no counter is synthesised.

Verification
REQ-024 SHALL cover the following: with cfg_ready_i = 1, op = 6'd17, arg = 32'h1234, and STATUS returning 32'h00AB0001 on the 3rd poll, writes hit 08/09/0A/0B, CLR writes 32'h1, RSP0 = 32'hCAFE0900 -> rsp_valid_o with rsp_data_o = 32'hCAFE0900, rsp_status_o = 16'h00AB, and rsp_err_o = 0.
REQ-025 SHALL cover the following: STATUS returns 32'h00050002 -> CLR writes 32'h2, no RSP read, rsp_err_o = 1, and rsp_data_o = 0.
REQ-026 SHALL cover the following: STATUS returns 32'h00000003 -> CLR writes 32'h3 and rsp_err_o = 1.
REQ-027 SHALL cover the following: cfg_ready_i low for 5 cycles during WR_ARG -> cfg_addr_o = 5'h09 and cfg_data_o are held stable, and exactly one write is counted.
REQ-028 SHALL cover the following: with the macro defined, POLL_TIMEOUT = 4, and STATUS always 0 -> exactly 4 poll reads, then rsp_timeout_o = 1 and rsp_err_o = 1.
REQ-029 SHALL cover the following: rst_i pulsed during POLL -> cfg_valid_o = 0 next cycle, no rsp_valid_o, and a new request is accepted afterwards.
